// File: rtl/pll_lock_reset_pkg.sv
// Shared constants, state encoding and counter helper for the PLL lock / reset controller.
package pll_lock_reset_pkg;

  // Default cycle counts at the 50 MHz reference clock
  localparam int CNT_W_DEF              = 20;
  localparam int PLL_RST_CYCLES_DEF     = 16;
  localparam int LOCK_TIMEOUT_DEF       = 50000;
  localparam int LOCK_STABLE_CYCLES_DEF = 256;
  localparam int RELEASE_DELAY_DEF      = 64;
  localparam int MAX_RETRIES_DEF        = 3;

  // Width of the retry counter output
  localparam int RETRY_W = 2;

  // Controller states, kept as plain constants so older tools can consume them
  typedef logic [2:0] state_t;
  localparam state_t S_PLL_RST   = 3'd0;
  localparam state_t S_WAIT_LOCK = 3'd1;
  localparam state_t S_STABLE    = 3'd2;
  localparam state_t S_RELEASE   = 3'd3;
  localparam state_t S_RUN       = 3'd4;
  localparam state_t S_FAIL      = 3'd5;

  // True when a zero-based counter has reached the last cycle of a phase lasting 'cycles'
  function automatic logic cnt_done(input logic [31:0] cnt, input int unsigned cycles);
    return cnt == (cycles - 32'd1);
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser with synchronous reset to 0, for asynchronous status inputs.
module pll_lock_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // First flop may go metastable; second flop gives the settled, usable value
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_reset_ctrl.sv
// Drives the PLL reset, qualifies lock stability and sequences the downstream system reset.
module pll_lock_reset_ctrl
  import pll_lock_reset_pkg::*;
#(
  parameter int PLL_RST_CYCLES     = PLL_RST_CYCLES_DEF,
  parameter int LOCK_TIMEOUT       = LOCK_TIMEOUT_DEF,
  parameter int LOCK_STABLE_CYCLES = LOCK_STABLE_CYCLES_DEF,
  parameter int RELEASE_DELAY      = RELEASE_DELAY_DEF,
  parameter int MAX_RETRIES        = MAX_RETRIES_DEF,
  parameter int CNT_W              = CNT_W_DEF
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               locked,
  input  logic               clear_status,
  output logic               pll_rst,
  output logic               sys_rst,
  output logic               ready,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_count,
  output logic               fail
);

  localparam logic [RETRY_W-1:0] MAX_RETRY_CNT = RETRY_W'(MAX_RETRIES);

  logic               locked_s;
  state_t             state;
  state_t             state_n;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_n;
  logic [RETRY_W-1:0] retry_n;
  logic               lost_set;

  pll_lock_sync #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (locked),
    .q   (locked_s)
  );

  // Next-state, shared counter and retry bookkeeping; a lock change always beats a terminal count
  always_comb begin
    state_n  = state;
    cnt_n    = cnt + CNT_W'(1);
    retry_n  = retry_count;
    lost_set = 1'b0;
    case (state)
      S_PLL_RST: begin
        if (cnt_done(32'(cnt), PLL_RST_CYCLES)) begin
          state_n = S_WAIT_LOCK;
          cnt_n   = '0;
        end
      end
      S_WAIT_LOCK: begin
        if (locked_s) begin
          state_n = S_STABLE;
          cnt_n   = '0;
        end else if (cnt_done(32'(cnt), LOCK_TIMEOUT)) begin
          cnt_n = '0;
          if (retry_count == MAX_RETRY_CNT) begin
            state_n = S_FAIL;
          end else begin
            retry_n = retry_count + RETRY_W'(1);
            state_n = S_PLL_RST;
          end
        end
      end
      S_STABLE: begin
        if (!locked_s) begin
          state_n = S_WAIT_LOCK;
          cnt_n   = '0;
        end else if (cnt_done(32'(cnt), LOCK_STABLE_CYCLES)) begin
          state_n = S_RELEASE;
          cnt_n   = '0;
        end
      end
      S_RELEASE: begin
        if (!locked_s) begin
          lost_set = 1'b1;
          state_n  = S_PLL_RST;
          cnt_n    = '0;
        end else if (cnt_done(32'(cnt), RELEASE_DELAY)) begin
          state_n = S_RUN;
          cnt_n   = '0;
          retry_n = '0;
        end
      end
      S_RUN: begin
        cnt_n = '0;
        if (!locked_s) begin
          lost_set = 1'b1;
          state_n  = S_PLL_RST;
        end
      end
      S_FAIL: begin
        cnt_n = '0;
        if (clear_status) begin
          state_n = S_PLL_RST;
          retry_n = '0;
        end
      end
      default: begin
        state_n = S_PLL_RST;
        cnt_n   = '0;
      end
    endcase
  end

  // State, counter and outputs all registered from the next state so every output is glitch-free
  always_ff @(posedge refclk) begin
    if (rst) begin
      state       <= S_PLL_RST;
      cnt         <= '0;
      pll_rst     <= 1'b1;
      sys_rst     <= 1'b1;
      ready       <= 1'b0;
      lock_lost   <= 1'b0;
      retry_count <= '0;
      fail        <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      retry_count <= retry_n;
      pll_rst     <= (state_n == S_PLL_RST) || (state_n == S_FAIL);
      sys_rst     <= (state_n != S_RUN);
      ready       <= (state_n == S_RUN);
      fail        <= (state_n == S_FAIL);
      if (lost_set) begin
        lock_lost <= 1'b1;
      end else if (clear_status) begin
        lock_lost <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pll_lock_reset_ctrl.sv
// Directed self-checking bench for pll_lock_reset_ctrl with shortened cycle counts.
module tb_pll_lock_reset_ctrl;

  logic       refclk = 1'b0;
  logic       rst;
  logic       locked;
  logic       clear_status;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       lock_lost;
  logic [1:0] retry_count;
  logic       fail;

  int tests_run    = 0;
  int tests_failed = 0;

  // Observed vector: {pll_rst, sys_rst, ready, lock_lost, retry_count[1:0], fail}
  logic [6:0] obs;
  assign obs = {pll_rst, sys_rst, ready, lock_lost, retry_count, fail};

  pll_lock_reset_ctrl #(
    .PLL_RST_CYCLES     (4),
    .LOCK_TIMEOUT       (20),
    .LOCK_STABLE_CYCLES (8),
    .RELEASE_DELAY      (4),
    .MAX_RETRIES        (3),
    .CNT_W              (20)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .locked       (locked),
    .clear_status (clear_status),
    .pll_rst      (pll_rst),
    .sys_rst      (sys_rst),
    .ready        (ready),
    .lock_lost    (lock_lost),
    .retry_count  (retry_count),
    .fail         (fail)
  );

  // 100 MHz sim clock; absolute period is irrelevant to the cycle-based checks
  always #5 refclk = ~refclk;

  // Advance n rising edges and settle 1 ns past the last one for driving and sampling
  task automatic step(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; locked = 1'b0; clear_status = 1'b0;
    step(3);
    tests_run++; if (obs !== 7'b1_1_0_0_00_0) begin tests_failed++; $display("[TB] FAIL reset_values: got %b want %b", obs, 7'b1_1_0_0_00_0); end
  endtask

  task automatic test_nominal();
    rst = 1'b0;
    step(3);
    tests_run++; if (obs !== 7'b1_1_0_0_00_0) begin tests_failed++; $display("[TB] FAIL nom_pll_rst_hold: got %b want %b", obs, 7'b1_1_0_0_00_0); end
    step(1);
    tests_run++; if (obs !== 7'b0_1_0_0_00_0) begin tests_failed++; $display("[TB] FAIL nom_pll_rst_release: got %b want %b", obs, 7'b0_1_0_0_00_0); end
    step(9);
    tests_run++; if (obs !== 7'b0_1_0_0_00_0) begin tests_failed++; $display("[TB] FAIL nom_wait_lock: got %b want %b", obs, 7'b0_1_0_0_00_0); end
    locked = 1'b1;
    step(14);
    tests_run++; if (obs !== 7'b0_1_0_0_00_0) begin tests_failed++; $display("[TB] FAIL nom_before_release: got %b want %b", obs, 7'b0_1_0_0_00_0); end
    step(1);
    tests_run++; if (obs !== 7'b0_0_1_0_00_0) begin tests_failed++; $display("[TB] FAIL nom_run: got %b want %b", obs, 7'b0_0_1_0_00_0); end
  endtask

  task automatic test_unstable_lock();
    rst = 1'b1; locked = 1'b0; clear_status = 1'b0;
    step(3);
    rst = 1'b0;
    step(4);
    tests_run++; if (obs !== 7'b0_1_0_0_00_0) begin tests_failed++; $display("[TB] FAIL unst_wait_lock: got %b want %b", obs, 7'b0_1_0_0_00_0); end
    locked = 1'b1;
    step(5);
    locked = 1'b0;
    step(2);
    locked = 1'b1;
    step(14);
    tests_run++; if (obs !== 7'b0_1_0_0_00_0) begin tests_failed++; $display("[TB] FAIL unst_no_early_release: got %b want %b", obs, 7'b0_1_0_0_00_0); end
    step(1);
    tests_run++; if (obs !== 7'b0_0_1_0_00_0) begin tests_failed++; $display("[TB] FAIL unst_run: got %b want %b", obs, 7'b0_0_1_0_00_0); end
  endtask

  task automatic test_timeout_fail();
    rst = 1'b1; locked = 1'b0; clear_status = 1'b0;
    step(3);
    rst = 1'b0;
    step(23);
    tests_run++; if (obs !== 7'b0_1_0_0_00_0) begin tests_failed++; $display("[TB] FAIL to_before_first: got %b want %b", obs, 7'b0_1_0_0_00_0); end
    step(1);
    tests_run++; if (obs !== 7'b1_1_0_0_01_0) begin tests_failed++; $display("[TB] FAIL to_retry1: got %b want %b", obs, 7'b1_1_0_0_01_0); end
    step(3);
    tests_run++; if (obs !== 7'b1_1_0_0_01_0) begin tests_failed++; $display("[TB] FAIL to_retry1_pulse: got %b want %b", obs, 7'b1_1_0_0_01_0); end
    step(1);
    tests_run++; if (obs !== 7'b0_1_0_0_01_0) begin tests_failed++; $display("[TB] FAIL to_retry1_end: got %b want %b", obs, 7'b0_1_0_0_01_0); end
    step(20);
    tests_run++; if (obs !== 7'b1_1_0_0_10_0) begin tests_failed++; $display("[TB] FAIL to_retry2: got %b want %b", obs, 7'b1_1_0_0_10_0); end
    step(4);
    tests_run++; if (obs !== 7'b0_1_0_0_10_0) begin tests_failed++; $display("[TB] FAIL to_retry2_end: got %b want %b", obs, 7'b0_1_0_0_10_0); end
    step(20);
    tests_run++; if (obs !== 7'b1_1_0_0_11_0) begin tests_failed++; $display("[TB] FAIL to_retry3: got %b want %b", obs, 7'b1_1_0_0_11_0); end
    step(4);
    tests_run++; if (obs !== 7'b0_1_0_0_11_0) begin tests_failed++; $display("[TB] FAIL to_retry3_end: got %b want %b", obs, 7'b0_1_0_0_11_0); end
    step(19);
    tests_run++; if (obs !== 7'b0_1_0_0_11_0) begin tests_failed++; $display("[TB] FAIL to_before_fail: got %b want %b", obs, 7'b0_1_0_0_11_0); end
    step(1);
    tests_run++; if (obs !== 7'b1_1_0_0_11_1) begin tests_failed++; $display("[TB] FAIL to_fail: got %b want %b", obs, 7'b1_1_0_0_11_1); end
    step(10);
    tests_run++; if (obs !== 7'b1_1_0_0_11_1) begin tests_failed++; $display("[TB] FAIL to_fail_held: got %b want %b", obs, 7'b1_1_0_0_11_1); end
    clear_status = 1'b1;
    step(1);
    clear_status = 1'b0;
    tests_run++; if (obs !== 7'b1_1_0_0_00_0) begin tests_failed++; $display("[TB] FAIL to_clear: got %b want %b", obs, 7'b1_1_0_0_00_0); end
    step(3);
    tests_run++; if (obs !== 7'b1_1_0_0_00_0) begin tests_failed++; $display("[TB] FAIL to_new_pulse: got %b want %b", obs, 7'b1_1_0_0_00_0); end
    step(1);
    tests_run++; if (obs !== 7'b0_1_0_0_00_0) begin tests_failed++; $display("[TB] FAIL to_new_pulse_end: got %b want %b", obs, 7'b0_1_0_0_00_0); end
  endtask

  task automatic test_lock_loss_run();
    rst = 1'b1; locked = 1'b1; clear_status = 1'b0;
    step(3);
    rst = 1'b0;
    step(17);
    tests_run++; if (obs !== 7'b0_0_1_0_00_0) begin tests_failed++; $display("[TB] FAIL loss_in_run: got %b want %b", obs, 7'b0_0_1_0_00_0); end
    locked = 1'b0;
    step(1);
    locked = 1'b1;
    step(1);
    tests_run++; if (obs !== 7'b0_0_1_0_00_0) begin tests_failed++; $display("[TB] FAIL loss_sync_delay: got %b want %b", obs, 7'b0_0_1_0_00_0); end
    step(1);
    tests_run++; if (obs !== 7'b1_1_0_1_00_0) begin tests_failed++; $display("[TB] FAIL loss_react: got %b want %b", obs, 7'b1_1_0_1_00_0); end
    step(3);
    tests_run++; if (obs !== 7'b1_1_0_1_00_0) begin tests_failed++; $display("[TB] FAIL loss_pll_pulse: got %b want %b", obs, 7'b1_1_0_1_00_0); end
    step(13);
    tests_run++; if (obs !== 7'b0_1_0_1_00_0) begin tests_failed++; $display("[TB] FAIL loss_reseq_release: got %b want %b", obs, 7'b0_1_0_1_00_0); end
    step(1);
    tests_run++; if (obs !== 7'b0_0_1_1_00_0) begin tests_failed++; $display("[TB] FAIL loss_reseq_run: got %b want %b", obs, 7'b0_0_1_1_00_0); end
    clear_status = 1'b1;
    step(1);
    clear_status = 1'b0;
    tests_run++; if (obs !== 7'b0_0_1_0_00_0) begin tests_failed++; $display("[TB] FAIL loss_clear: got %b want %b", obs, 7'b0_0_1_0_00_0); end
  endtask

  task automatic test_simultaneous();
    locked = 1'b0;
    step(1);
    locked = 1'b1;
    step(1);
    tests_run++; if (obs !== 7'b0_0_1_0_00_0) begin tests_failed++; $display("[TB] FAIL simul_pre: got %b want %b", obs, 7'b0_0_1_0_00_0); end
    clear_status = 1'b1;
    step(1);
    clear_status = 1'b0;
    tests_run++; if (obs !== 7'b1_1_0_1_00_0) begin tests_failed++; $display("[TB] FAIL simul_set_wins: got %b want %b", obs, 7'b1_1_0_1_00_0); end
  endtask

  task automatic test_reset_mid_sequence();
    step(14);
    tests_run++; if (obs !== 7'b0_1_0_1_00_0) begin tests_failed++; $display("[TB] FAIL mid_in_release: got %b want %b", obs, 7'b0_1_0_1_00_0); end
    rst = 1'b1;
    step(1);
    tests_run++; if (obs !== 7'b1_1_0_0_00_0) begin tests_failed++; $display("[TB] FAIL mid_reset_values: got %b want %b", obs, 7'b1_1_0_0_00_0); end
    rst = 1'b0;
    step(3);
    tests_run++; if (obs !== 7'b1_1_0_0_00_0) begin tests_failed++; $display("[TB] FAIL mid_restart_pulse: got %b want %b", obs, 7'b1_1_0_0_00_0); end
    step(1);
    tests_run++; if (obs !== 7'b0_1_0_0_00_0) begin tests_failed++; $display("[TB] FAIL mid_restart_pulse_end: got %b want %b", obs, 7'b0_1_0_0_00_0); end
    step(12);
    tests_run++; if (obs !== 7'b0_1_0_0_00_0) begin tests_failed++; $display("[TB] FAIL mid_before_run: got %b want %b", obs, 7'b0_1_0_0_00_0); end
    step(1);
    tests_run++; if (obs !== 7'b0_0_1_0_00_0) begin tests_failed++; $display("[TB] FAIL mid_run: got %b want %b", obs, 7'b0_0_1_0_00_0); end
  endtask

  // Scenario sequence; test_simultaneous and test_reset_mid_sequence continue from the prior state
  initial begin
    rst = 1'b1;
    locked = 1'b0;
    clear_status = 1'b0;
    test_reset();
    test_nominal();
    test_unstable_lock();
    test_timeout_fail();
    test_lock_loss_run();
    test_simultaneous();
    test_reset_mid_sequence();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
